// File: rtl/test_status_monitor_if.sv
// test_status_monitor_if: per-channel tty write bus snooped by the end-of-test monitor
//   we         N_CH          per-channel write enable
//   write_addr N_CH*ADDR_W   channel i at [i*ADDR_W +: ADDR_W]
//   data_in    N_CH*DATA_W   channel i at [i*DATA_W +: DATA_W]
interface test_status_monitor_if #(
  parameter int N_CH   = 1,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]        we;
  logic [N_CH*ADDR_W-1:0] write_addr;
  logic [N_CH*DATA_W-1:0] data_in;
  modport master (output we, write_addr, data_in);
  modport slave  (input  we, write_addr, data_in);
endinterface

// File: rtl/test_status_monitor.sv
// test_status_monitor: snoops N_CH tty write ports for done/fail codewords, aggregates pass/fail, times the run
//   clock, reset (async active-low), wr (slave bus: we/write_addr/data_in), clear (sync re-arm)
//   ch_done/ch_fail sticky per channel; test_end one-cycle pulse; test_pass/test_fail/timeout sticky; cycle_count RUN cycles
//   Optional watchdog enabled by defining STATUS_MON_TIMEOUT_EN
module test_status_monitor #(
  parameter int                N_CH        = 1,
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] DONE_ADDR   = 10'h000,
  parameter logic [DATA_W-1:0] DONE_DATA   = 32'h000000FF,
  parameter logic [DATA_W-1:0] FAIL_DATA   = 32'h0000DEAD,
  parameter int                CNT_W       = 32,
  parameter int                TIMEOUT_CYC = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  test_status_monitor_if.slave    wr,
  input  logic                    clear,
  output logic [N_CH-1:0]         ch_done,
  output logic [N_CH-1:0]         ch_fail,
  output logic                    test_end,
  output logic                    test_pass,
  output logic                    test_fail,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;
  state_t            state_q, state_d;
  logic [N_CH-1:0]   hit_done, hit_fail, done_q, done_d, fail_q, fail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              te_q, te_d, pass_q, pass_d, tfail_q, tfail_d;
  logic              go_end, wd_fire;
  for (genvar i = 0; i < N_CH; i++) begin : g_hit
    logic at_done;
    assign at_done     = wr.we[i] && wr.write_addr[i*ADDR_W +: ADDR_W] == DONE_ADDR;
    assign hit_done[i] = at_done && wr.data_in[i*DATA_W +: DATA_W] == DONE_DATA;
    assign hit_fail[i] = at_done && wr.data_in[i*DATA_W +: DATA_W] == FAIL_DATA;
  end
`ifdef STATUS_MON_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  // Fires on the RUN cycle that completes TIMEOUT_CYC silent cycles
  assign wd_fire = state_q == S_RUN && !(|wr.we) && wd_q == WD_W'(TIMEOUT_CYC - 1);
  assign wd_d    = (clear || state_q != S_RUN || |wr.we) ? '0 : wd_q + 1'b1;
  assign to_d    = !clear && (to_q || wd_fire);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  assign timeout = to_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif
  // done_d/fail_d already include this cycle's hits, so the END decision sees them
  always_comb begin
    done_d  = clear ? '0 : done_q | (state_q != S_END ? hit_done : '0);
    fail_d  = clear ? '0 : fail_q | (state_q != S_END ? hit_fail : '0);
    go_end  = state_q == S_RUN && (&done_d || |fail_d || wd_fire);
    state_d = clear ? S_IDLE : go_end ? S_END : (state_q == S_IDLE && |wr.we) ? S_RUN : state_q;
    cnt_d   = clear ? '0 : (state_q == S_RUN && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    te_d    = !clear && go_end;
    pass_d  = clear ? 1'b0 : go_end ? (&done_d && !(|fail_d) && !wd_fire) : pass_q;
    tfail_d = clear ? 1'b0 : go_end ? (|fail_d || wd_fire) : tfail_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      done_q  <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      te_q    <= 1'b0;
      pass_q  <= 1'b0;
      tfail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      te_q    <= te_d;
      pass_q  <= pass_d;
      tfail_q <= tfail_d;
    end
  assign ch_done     = done_q;
  assign ch_fail     = fail_q;
  assign test_end    = te_q;
  assign test_pass   = pass_q;
  assign test_fail   = tfail_q;
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_test_status_monitor.sv
// tb_test_status_monitor: table vectors, hand sequences and random stimulus against a rule-level model
module tb_test_status_monitor;
  localparam logic [31:0] FF = 32'h000000FF, DE = 32'h0000DEAD, CH = 32'h00000041;
`ifdef STATUS_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, clear = 0;
  logic [3:0]  ch_done, ch_fail;
  logic        test_end, test_pass, test_fail, timeout;
  logic [31:0] cycle_count;
  test_status_monitor_if #(.N_CH(4), .ADDR_W(10), .DATA_W(32)) bus ();
  test_status_monitor #(.N_CH(4), .TIMEOUT_CYC(50)) dut (
    .clock(clk), .reset(rst_n), .wr(bus), .clear(clear),
    .ch_done(ch_done), .ch_fail(ch_fail), .test_end(test_end), .test_pass(test_pass),
    .test_fail(test_fail), .timeout(timeout), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Reference model: plain rules (running/ended flags, bit sets, integer counts)
  bit m_run, m_end, m_te, m_pass, m_tf, m_to;
  bit [3:0] m_done, m_fail;
  longint m_cnt;
  int m_idle;
  task automatic model_reset();
    {m_run, m_end, m_te, m_pass, m_tf, m_to} = '0;
    m_done = 0; m_fail = 0; m_cnt = 0; m_idle = 0;
  endtask
  task automatic model_step(input logic [3:0] we, input logic [39:0] a, input logic [127:0] d, input logic clr);
    bit wd;
    m_te = 0;
    if (clr) begin model_reset(); return; end
    if (m_end) return;
    for (int c = 0; c < 4; c++)
      if (we[c] && a[c*10 +: 10] == 0) begin
        if (d[c*32 +: 32] == FF) m_done[c] = 1;
        if (d[c*32 +: 32] == DE) m_fail[c] = 1;
      end
    if (!m_run) begin
      if (we != 0) m_run = 1;
      return;
    end
    m_cnt = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
    m_idle = (we != 0) ? 0 : m_idle + 1;
    wd = TO_EN && m_idle >= 50;
    if (m_done == 4'hF || m_fail != 0 || wd) begin
      m_end = 1; m_te = 1; m_to = wd;
      m_pass = m_done == 4'hF && m_fail == 0 && !wd;
      m_tf = !m_pass;
    end
  endtask
  task automatic cmp_model();
    chk("ch_done", ch_done, m_done);
    chk("ch_fail", ch_fail, m_fail);
    chk("test_end", test_end, m_te);
    chk("test_pass", test_pass, m_pass);
    chk("test_fail", test_fail, m_tf);
    chk("timeout", timeout, m_to);
    chk("cycle_count", cycle_count, m_cnt);
  endtask
  task automatic cyc(input logic [3:0] we, input logic [39:0] a, input logic [127:0] d, input logic clr);
    @(negedge clk);
    bus.we = we; bus.write_addr = a; bus.data_in = d; clear = clr;
    @(posedge clk);
    model_step(we, a, d, clr);
    #1 cmp_model();
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_outs"}, {ch_done, ch_fail, test_end, test_pass, test_fail, timeout}, 0);
    chk({n, "_cnt"}, cycle_count, 0);
  endtask
  typedef struct {
    logic [3:0] we; logic [39:0] a; logic [127:0] d; logic clr;
    logic [3:0] e_done, e_fail; logic e_end, e_pass, e_tf;
  } vec_t;
  vec_t tv[10];
  initial begin
    int te_at;
    logic [3:0] we;
    logic [39:0] a;
    logic [127:0] d;
    bus.we = 0; bus.write_addr = 0; bus.data_in = 0;
    tv[0] = '{4'b0001, 40'h0, {CH, CH, CH, CH}, 0, 4'b0000, 4'b0000, 0, 0, 0};
    tv[1] = '{4'b0001, {10'h0, 10'h0, 10'h0, 10'h4}, {FF, FF, FF, FF}, 0, 4'b0000, 4'b0000, 0, 0, 0};
    tv[2] = '{4'b0011, 40'h0, {CH, CH, DE, FF}, 0, 4'b0001, 4'b0010, 1, 0, 1};
    tv[3] = '{4'b1111, 40'h0, {FF, FF, FF, FF}, 0, 4'b0001, 4'b0010, 0, 0, 1};
    tv[4] = '{4'b0100, 40'h0, {FF, FF, FF, FF}, 1, 4'b0000, 4'b0000, 0, 0, 0};
    tv[5] = '{4'b0100, 40'h0, {FF, FF, FF, FF}, 0, 4'b0100, 4'b0000, 0, 0, 0};
    tv[6] = '{4'b0100, 40'h0, {FF, FF, FF, FF}, 0, 4'b0100, 4'b0000, 0, 0, 0};
    tv[7] = '{4'b1011, 40'h0, {FF, CH, FF, FF}, 0, 4'b1111, 4'b0000, 1, 1, 0};
    tv[8] = '{4'b1111, 40'h0, {FF, FF, FF, FF}, 0, 4'b1111, 4'b0000, 0, 1, 0};
    tv[9] = '{4'b0000, 40'h0, 128'h0, 1, 4'b0000, 4'b0000, 0, 0, 0};
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    foreach (tv[i]) begin
      cyc(tv[i].we, tv[i].a, tv[i].d, tv[i].clr);
      chk($sformatf("tv%0d_done", i), ch_done, tv[i].e_done);
      chk($sformatf("tv%0d_fail", i), ch_fail, tv[i].e_fail);
      chk($sformatf("tv%0d_flags", i), {test_end, test_pass, test_fail}, {tv[i].e_end, tv[i].e_pass, tv[i].e_tf});
    end
    // Console char then all DONE twenty cycles later
    cyc(4'b0001, 40'h0, {CH, CH, CH, CH}, 0);
    repeat (19) cyc(0, 40'h0, 128'h0, 0);
    cyc(4'b1111, 40'h0, {FF, FF, FF, FF}, 0);
    chk("run20_flags", {test_end, test_pass, test_fail}, 3'b110);
    chk("run20_cnt", cycle_count, 20);
    repeat (5) cyc(4'b1111, 40'h0, {DE, DE, DE, DE}, 0);
    chk("run20_frozen", {test_end, test_pass, ch_fail, cycle_count}, {1'b0, 1'b1, 4'b0, 32'd20});
    cyc(0, 40'h0, 128'h0, 1);
    // Staggered DONE: ch0 at 5, ch1/ch2 at 9, ch3 at 30
    cyc(4'b0001, 40'h0, {CH, CH, CH, CH}, 0);
    for (int t = 1; t <= 30; t++) begin
      we = {t == 30, t == 9, t == 9, t == 5};
      cyc(we, 40'h0, {FF, FF, FF, FF}, 0);
      if (t == 29) chk("stag_noend", {test_end, ch_done}, {1'b0, 4'b0111});
    end
    chk("stag_end", {test_end, test_pass, cycle_count}, {1'b1, 1'b1, 32'd30});
    repeat (3) cyc(4'b1111, 40'h0, {FF, FF, FF, FF}, 0);
    chk("stag_frozen", {test_end, cycle_count}, {1'b0, 32'd30});
    cyc(0, 40'h0, 128'h0, 1);
    // Watchdog: one write then silence
    te_at = -1;
    cyc(4'b0001, 40'h0, {CH, CH, CH, CH}, 0);
    for (int k = 1; k <= 60; k++) begin
      cyc(0, 40'h0, 128'h0, 0);
      if (test_end && te_at < 0) te_at = k;
    end
    chk("wd_end_at", te_at, TO_EN ? 50 : -1);
    chk("wd_flags", {timeout, test_fail, test_pass}, {TO_EN, TO_EN, 1'b0});
    cyc(0, 40'h0, 128'h0, 1);
    // Async reset mid-RUN with partial done
    cyc(4'b0011, 40'h0, {CH, CH, FF, FF}, 0);
    cyc(0, 40'h0, 128'h0, 0);
    cyc(0, 40'h0, 128'h0, 0);
    chk("pre_rst_done", ch_done, 4'b0011);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk_zero("midrun_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(4'b0010, 40'h0, {CH, CH, DE, CH}, 0);
    cyc(0, 40'h0, 128'h0, 0);
    chk("after_rst_fail", {test_end, test_fail, test_pass, cycle_count}, {3'b110, 32'd1});
    cyc(0, 40'h0, 128'h0, 1);
    chk_zero("clear_after_end");
    cyc(4'b1111, 40'h0, {FF, FF, FF, FF}, 0);
    cyc(0, 40'h0, 128'h0, 0);
    chk("new_test_pass", {test_end, test_pass, test_fail, cycle_count}, {3'b110, 32'd1});
    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        int r;
        a[c*10 +: 10] = ($urandom_range(3) == 0) ? 10'($urandom) : 10'h0;
        r = $urandom_range(63);
        d[c*32 +: 32] = (r == 0) ? DE : (r < 5) ? FF : (r < 8) ? 32'($urandom) : CH;
      end
      we = 4'($urandom) & 4'($urandom);
      cyc(we, a, d, $urandom_range(60) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
